// File: rtl/digital_tube_scan_driver.sv
// Time-multiplexed driver for a 6-digit common-bus 7-segment module.
// One digit is lit per slot. Each slot opens with a blanking window that
// suppresses ghosting, and the lit part of the slot is PWM-dimmed with a
// 4-bit duty. Every output is registered.
module digital_tube_scan_driver #(
  parameter int SLOT_CYC       = 25000,
  parameter int BLANK_CYC      = 250,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] brightness,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  input  logic [6:0] hex2,
  input  logic [6:0] hex3,
  input  logic [6:0] hex4,
  input  logic [6:0] hex5,
  output logic [6:0] seg,
  output logic [5:0] dig_sel,
  output logic       frame_done
);

  localparam int              NUM_DIGITS = 6;
  localparam int              CW         = $clog2(SLOT_CYC);
  localparam logic [CW-1:0]   SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [6:0]      SEG_OFF    = 7'h7F;
  localparam logic [5:0]      SEL_OFF    = SEL_ACTIVE_LOW ? 6'h3F : 6'h00;

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t          state, state_nxt;
  logic [2:0]      digit, digit_nxt;
  logic [CW-1:0]   slot_cnt, slot_cnt_nxt;
  logic [3:0]      pwm_cnt, pwm_cnt_nxt;
  logic [6:0]      seg_hold;
  logic [6:0]      hex_cur;
  logic [NUM_DIGITS-1:0] digit_hot;
  logic            lit;
  logic            wrap;

  // Segment code of the digit currently being scanned.
  always_comb begin
    case (digit)
      3'd0:    hex_cur = hex0;
      3'd1:    hex_cur = hex1;
      3'd2:    hex_cur = hex2;
      3'd3:    hex_cur = hex3;
      3'd4:    hex_cur = hex4;
      3'd5:    hex_cur = hex5;
      default: hex_cur = SEG_OFF;
    endcase
  end

  // One-hot decode of the digit index, before select-line polarity is applied.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_hot
    assign digit_hot[k] = (digit == 3'(k));
  end

  // Next-state and counter logic. Dropping enable overrides everything and
  // parks the scan in IDLE with every counter cleared. lit and wrap are only
  // raised while enabled, so a disable is already dark in the next cycle and
  // a disable on the wrap cycle suppresses frame_done.
  always_comb begin
    state_nxt    = state;
    digit_nxt    = digit;
    slot_cnt_nxt = slot_cnt;
    pwm_cnt_nxt  = pwm_cnt;
    lit          = 1'b0;
    wrap         = 1'b0;
    if (!enable) begin
      state_nxt    = IDLE;
      digit_nxt    = 3'd0;
      slot_cnt_nxt = '0;
      pwm_cnt_nxt  = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt    = BLANK;
          digit_nxt    = 3'd0;
          slot_cnt_nxt = '0;
          pwm_cnt_nxt  = 4'd0;
        end
        BLANK: begin
          slot_cnt_nxt = slot_cnt + 1'b1;
          if (slot_cnt == BLANK_LAST) begin
            state_nxt   = ON;
            pwm_cnt_nxt = 4'd0;
          end
        end
        ON: begin
          lit          = (pwm_cnt < brightness);
          pwm_cnt_nxt  = pwm_cnt + 4'd1;
          slot_cnt_nxt = slot_cnt + 1'b1;
          if (slot_cnt == SLOT_LAST) begin
            wrap         = 1'b1;
            state_nxt    = BLANK;
            slot_cnt_nxt = '0;
            pwm_cnt_nxt  = 4'd0;
            digit_nxt    = (digit == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit + 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Scan state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      digit    <= 3'd0;
      slot_cnt <= '0;
      pwm_cnt  <= 4'd0;
    end else begin
      state    <= state_nxt;
      digit    <= digit_nxt;
      slot_cnt <= slot_cnt_nxt;
      pwm_cnt  <= pwm_cnt_nxt;
    end
  end

  // Latch the digit's code on the first blank cycle so mid-slot input
  // changes never tear the displayed digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seg_hold <= SEG_OFF;
    else if (enable && state == BLANK && slot_cnt == '0)
      seg_hold <= hex_cur;
  end

  // Registered outputs. seg and dig_sel share one condition so the bus
  // never carries a code while no digit is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dig_sel    <= SEL_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= lit ? seg_hold : SEG_OFF;
      dig_sel    <= lit ? (SEL_ACTIVE_LOW ? ~digit_hot : digit_hot) : SEL_OFF;
      frame_done <= wrap && (digit == 3'(NUM_DIGITS - 1));
    end
  end

endmodule

// File: tb/tb_digital_tube_scan_driver.sv
// Bench for digital_tube_scan_driver: two instances (active-low and
// active-high digit select) share one stimulus stream. A scan-position model
// pushes the expected outputs for each cycle onto a queue before the clock
// edge. The expected outputs are popped and compared after the edge.
module tb_digital_tube_scan_driver;

  localparam int SLOT  = 40;
  localparam int BLANK = 4;
  localparam int FRAME = 6 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] brightness = 4'd0;
  logic [6:0] hexv [6];
  logic [6:0] seg_a, seg_b;
  logic [5:0] sel_a, sel_b;
  logic       fd_a, fd_b;

  typedef struct {
    logic [6:0] seg;
    logic [5:0] sel_lo;
    logic [5:0] sel_hi;
    logic       fd;
  } exp_t;

  exp_t       sb[$];
  int         p = -1;          // scan position since BLANK entry; -1 = idle
  logic [6:0] snap = 7'h7F;    // code the driver should have latched
  int         checks = 0, errors = 0, lit_cnt = 0, fd_cnt = 0;

  digital_tube_scan_driver #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .SEL_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
    .hex0(hexv[0]), .hex1(hexv[1]), .hex2(hexv[2]), .hex3(hexv[3]), .hex4(hexv[4]), .hex5(hexv[5]),
    .seg(seg_a), .dig_sel(sel_a), .frame_done(fd_a));

  digital_tube_scan_driver #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .SEL_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
    .hex0(hexv[0]), .hex1(hexv[1]), .hex2(hexv[2]), .hex3(hexv[3]), .hex4(hexv[4]), .hex5(hexv[5]),
    .seg(seg_b), .dig_sel(sel_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (p=%0d t=%0t)", tag, obs, exp, p, $time);
    end
  endtask

  // One clock: predict from the current inputs, push, clock, pop, compare.
  task automatic tick();
    exp_t e;
    int   off, dig;
    e.seg = 7'h7F; e.sel_lo = 6'h3F; e.sel_hi = 6'h00; e.fd = 1'b0;
    if (!rst_n || !enable) begin
      p = -1;
    end else if (p < 0) begin
      p = 0;
    end else begin
      off = p % SLOT;
      dig = (p / SLOT) % 6;
      if (off == 0) snap = hexv[dig];
      if (off >= BLANK && ((off - BLANK) % 16) < int'(brightness)) begin
        e.seg    = snap;
        e.sel_hi = 6'(1 << dig);
        e.sel_lo = ~e.sel_hi;
      end
      e.fd = (p % FRAME == FRAME - 1);
      p++;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("seg_lo",     seg_a, e.seg);
    check("seg_hi",     seg_b, e.seg);
    check("sel_lo",     7'(sel_a), 7'(e.sel_lo));
    check("sel_hi",     7'(sel_b), 7'(e.sel_hi));
    check("fd_lo",      7'(fd_a), 7'(e.fd));
    check("fd_hi",      7'(fd_b), 7'(e.fd));
    if (sel_a != 6'h3F) lit_cnt++;
    if (fd_a) fd_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset held with random inputs
    for (int k = 0; k < 6; k++) hexv[k] = 7'($urandom);
    enable = 1'($urandom); brightness = 4'($urandom);
    for (int i = 0; i < 6; i++) begin
      tick();
      for (int k = 0; k < 6; k++) hexv[k] = 7'($urandom);
      enable = 1'($urandom); brightness = 4'($urandom);
    end

    // Release, idle for a few cycles
    rst_n = 1'b1; enable = 1'b0; brightness = 4'd15;
    for (int k = 0; k < 6; k++) hexv[k] = 7'(k + 1);
    run(3);

    // Scan order over two full frames
    enable = 1'b1; fd_cnt = 0;
    run(1 + 2 * FRAME);
    check("frame_done_count", 7'(fd_cnt), 7'd2);

    // PWM duty over one 36-cycle ON window: 15, 4, 0
    enable = 1'b0; run(1); enable = 1'b1; lit_cnt = 0; run(1 + SLOT);
    check("lit_b15", 7'(lit_cnt), 7'd34);
    brightness = 4'd4;
    enable = 1'b0; run(1); enable = 1'b1; lit_cnt = 0; run(1 + SLOT);
    check("lit_b4", 7'(lit_cnt), 7'd12);
    brightness = 4'd0;
    enable = 1'b0; run(1); enable = 1'b1; lit_cnt = 0; run(1 + SLOT);
    check("lit_b0", 7'(lit_cnt), 7'd0);

    // Snapshot: hex2 changes mid digit-2 slot, shown only from the next one
    enable = 1'b0; run(1);
    brightness = 4'd15; hexv[2] = 7'h40; enable = 1'b1;
    run(101);
    hexv[2] = 7'h79;
    run(261);

    // Enable drop mid digit-3 ON, then re-enable
    enable = 1'b0; run(1); enable = 1'b1;
    run(141);
    enable = 1'b0; fd_cnt = 0;
    run(3);
    enable = 1'b1;
    run(60);
    check("no_fd_after_drop", 7'(fd_cnt), 7'd0);

    // Disable on the frame wrap cycle: IDLE wins, no frame_done
    for (int g = 0; g < 400 && p != FRAME - 1; g++) tick();
    check("reached_wrap", 7'(p == FRAME - 1), 7'd1);
    enable = 1'b0; fd_cnt = 0;
    run(1);
    enable = 1'b1;
    run(45);
    check("no_fd_on_wrap_drop", 7'(fd_cnt), 7'd0);

    // Async reset mid-slot: dark immediately, restart from digit 0
    run(70);
    rst_n = 1'b0;
    #1;
    check("arst_seg_lo", seg_a, 7'h7F);
    check("arst_seg_hi", seg_b, 7'h7F);
    check("arst_sel_lo", 7'(sel_a), 7'h3F);
    check("arst_sel_hi", 7'(sel_b), 7'h00);
    check("arst_fd", 7'(fd_a | fd_b), 7'd0);
    run(2);
    rst_n = 1'b1;
    run(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
